// File: rtl/sketch_pkg.sv
// Shared types and defaults for the sketch counter-update engine.
package sketch_pkg;

  localparam int unsigned ADDR_WIDTH_DEF  = 19;
  localparam int unsigned COUNT_WIDTH_DEF = 36;
  localparam int unsigned BYTE_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    CLR
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [BYTE_WIDTH_DEF-1:0] bytes;
  } record_t;

endpackage

// File: rtl/sketch_update_fifo.sv
// Synchronous record FIFO; DEPTH must be a power of 2 (pointers wrap naturally).
module sketch_update_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 35
) (
  input  logic                     memclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge memclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge memclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sketch_update.sv
// Sketch counter engine: buffered {index, bytes} records drive a saturating
// read-modify-write on SRAM counters; also runs a full-table clear sweep.
module sketch_update
  import sketch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH  = BYTE_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   memclk,
  input  logic                   reset,
  input  logic [31:0]            hash_in,
  input  logic [BYTE_WIDTH-1:0]  byte_in,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [COUNT_WIDTH-1:0] sram_wdata,
  input  logic                   sram_gnt,
  input  logic                   sram_rvalid,
  input  logic [COUNT_WIDTH-1:0] sram_rdata,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic [31:0]            update_count,
  output logic [15:0]            sat_count
);

  localparam int unsigned RW = ADDR_WIDTH + BYTE_WIDTH;

  state_t                      state;
  logic                        clr_pend;
  logic [ADDR_WIDTH-1:0]       cur_addr;
  logic [BYTE_WIDTH-1:0]       cur_bytes;
  logic [ADDR_WIDTH-1:0]       cnt_addr;
  logic [COUNT_WIDTH:0]        sum;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic [RW-1:0]               fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        unused_bits;

  assign upd_ready   = !fifo_full;
  assign fifo_push   = upd_valid && upd_ready;
  assign fifo_pop    = (state == IDLE) && !clr_pend && !fifo_empty;
  assign unused_bits = ^{hash_in[31:ADDR_WIDTH], fifo_count};

  sketch_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .memclk (memclk),
    .reset  (reset),
    .push   (fifo_push),
    .din    ({hash_in[ADDR_WIDTH-1:0], byte_in}),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    sum = {1'b0, sram_rdata} + (COUNT_WIDTH+1)'(cur_bytes);
  end

  // sram_wdata doubles as the result register between RD_WAIT and WR_REQ.
  always_ff @(posedge memclk) begin
    if (reset) begin
      state        <= IDLE;
      clr_pend     <= 1'b0;
      clear_busy   <= 1'b0;
      cur_addr     <= '0;
      cur_bytes    <= '0;
      cnt_addr     <= '0;
      sram_req     <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      update_count <= '0;
      sat_count    <= '0;
    end else begin
      if (clear_start && state != CLR) begin
        clr_pend   <= 1'b1;
        clear_busy <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (clr_pend) begin
            state      <= CLR;
            clr_pend   <= 1'b0;
            cnt_addr   <= '0;
            sram_req   <= 1'b1;
            sram_we    <= 1'b1;
            sram_addr  <= '0;
            sram_wdata <= '0;
          end else if (!fifo_empty) begin
            {cur_addr, cur_bytes} <= fifo_dout;
            state     <= RD_REQ;
            sram_req  <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= fifo_dout[RW-1:BYTE_WIDTH];
          end
        end
        RD_REQ: begin
          if (sram_gnt) begin
            sram_req <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (sram_rvalid) begin
            if (sum[COUNT_WIDTH]) begin
              sram_wdata <= '1;
              if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
            end else begin
              sram_wdata <= sum[COUNT_WIDTH-1:0];
            end
            sram_req  <= 1'b1;
            sram_we   <= 1'b1;
            sram_addr <= cur_addr;
            state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (sram_gnt) begin
            sram_req     <= 1'b0;
            sram_we      <= 1'b0;
            update_count <= update_count + 32'd1;
            state        <= IDLE;
          end
        end
        CLR: begin
          if (sram_gnt) begin
            if (cnt_addr == '1) begin
              sram_req   <= 1'b0;
              sram_we    <= 1'b0;
              clear_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              cnt_addr  <= cnt_addr + 1'b1;
              sram_addr <= cnt_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
